// File: rtl/sweep4_pkg.sv
// Shared definitions for the four-input truth-table sweeper.
package sweep4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_VEC = 16;
    localparam int RESP_W  = 32;
    localparam int IDX_W   = 4;

endpackage

// File: rtl/sweep4_if.sv
// Control, vector and response signals between the sweeper and its environment.
interface sweep4_if;
    import sweep4_pkg::*;

    logic               start;
    logic               abort;
    logic               a;
    logic               b;
    logic               c;
    logic               d;
    logic               f_in;
    logic               g_in;
    logic [IDX_W-1:0]   vec_idx;
    logic               busy;
    logic               done;
    logic [RESP_W-1:0]  resp;

    modport master (
        output start, abort, f_in, g_in,
        input  a, b, c, d, vec_idx, busy, done, resp
    );

    modport slave (
        input  start, abort, f_in, g_in,
        output a, b, c, d, vec_idx, busy, done, resp
    );
endinterface

// File: rtl/sweep4_hold_cnt.sv
// Counts how long the current vector has been held; flags the sampling cycle.
module sweep4_hold_cnt #(
    parameter int unsigned HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);
    logic [7:0] count;

    assign last = (count == 8'(HOLD_CYCLES - 1));

    // Count 0..HOLD_CYCLES-1 and wrap, so the next vector starts from zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= last ? 8'd0 : count + 8'd1;
        end
    end
endmodule

// File: rtl/sweep4_seq.sv
// Steps a 4-bit vector through all 16 values, holding each for HOLD_CYCLES
// cycles and capturing the two downstream responses at the end of each hold.
module sweep4_seq
    import sweep4_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 20
) (
    input  logic     clk,
    input  logic     rst,
    sweep4_if.slave  bus
);
    if (HOLD_CYCLES == 0 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("sweep4_seq: HOLD_CYCLES must be in 1..255");
    end

    state_t              state_q;
    state_t              state_d;
    logic [IDX_W-1:0]    vec_q;
    logic [IDX_W-1:0]    vec_d;
    logic [RESP_W-1:0]   resp_q;
    logic [RESP_W-1:0]   resp_d;
    logic                cnt_clear;
    logic                cnt_enable;
    logic                last;

    sweep4_hold_cnt #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .last   (last)
    );

    // State, vector index and captured responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            resp_q  <= resp_d;
        end
    end

    // Next-state logic; abort is checked after the capture so a sampling-cycle
    // abort still keeps that vector's responses.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        resp_d     = resp_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = DRIVE;
                    vec_d     = '0;
                    resp_d    = '0;
                    cnt_clear = 1'b1;
                end
            end
            DRIVE: begin
                cnt_enable = 1'b1;
                if (last) begin
                    resp_d[{vec_q, 1'b0} +: 2] = {bus.f_in, bus.g_in};
                    if (vec_q == IDX_W'(NUM_VEC - 1)) begin
                        state_d = DONE;
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
                if (bus.abort) begin
                    state_d   = IDLE;
                    vec_d     = vec_q;
                    cnt_clear = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy                     = (state_q == DRIVE);
    assign bus.done                     = (state_q == DONE);
    assign {bus.a, bus.b, bus.c, bus.d} = bus.busy ? vec_q : 4'b0000;
    assign bus.vec_idx                  = vec_q;
    assign bus.resp                     = resp_q;
endmodule

// File: doc/sweep4_seq.md
SWEEP4_SEQ -- requirements
Module: sweep4_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 20: cycles each input vector is held before its response is sampled; legal range 1..255; 0 SHALL fail elaboration.
REQ-002 clk  input  1  the single clock; all logic SHALL be rising-edge clocked.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a sweep; acted on only in IDLE.
REQ-005 abort  input  1  terminates a running sweep.
REQ-006 a, b, c, d  output  1 each  vector driven to the downstream 4-input combinational stage; a is MSB.
REQ-007 f_in, g_in  input  1 each  responses from the downstream stage.
REQ-008 vec_idx  output  4  index of the vector currently driven.
REQ-009 busy  output  1  high in DRIVE.
REQ-010 done  output  1  one-cycle pulse when a full sweep completes.
REQ-011 resp  output  32  captured responses; resp[2i+1] = f_in and resp[2i] = g_in for vector i.

Function
REQ-012 States SHALL be IDLE, DRIVE and DONE.
REQ-013 IDLE: start=1 SHALL move to DRIVE, clear vec_idx and the hold counter, and clear resp.
REQ-014 {a,b,c,d} SHALL equal vec_idx whenever busy=1, and SHALL be 4'b0000 otherwise.
REQ-015 Latency: vector 0 SHALL appear on a..d in the cycle after start is accepted.
REQ-016 DRIVE: the hold counter SHALL count 0..HOLD_CYCLES-1.
REQ-017 At count HOLD_CYCLES-1, f_in and g_in SHALL be registered into resp[2*vec_idx+1 : 2*vec_idx].
REQ-018 At that same cycle, if vec_idx<15 the block SHALL increment vec_idx and clear the counter; if vec_idx=15 it SHALL go to DONE.
REQ-019 vec_idx SHALL NOT wrap: no vector beyond 15 is driven.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 A full sweep SHALL take 16*HOLD_CYCLES cycles in DRIVE, with done in the next cycle.
REQ-022 resp SHALL hold its value in IDLE until the next accepted start.
REQ-023 start in DRIVE or DONE SHALL be ignored; it is not queued.
REQ-024 abort in DRIVE SHALL return to IDLE next cycle with no done pulse; resp keeps only the vectors already sampled.
REQ-025 abort and start asserted together: in DRIVE abort wins; in IDLE start wins and abort has no effect.
REQ-026 abort in the sampling cycle SHALL still capture that vector, then go to IDLE.
REQ-027 With HOLD_CYCLES=1, every DRIVE cycle SHALL be a sampling cycle.

Reset
REQ-028 rst=1 SHALL force IDLE; a..d, vec_idx, busy, done, resp and the hold counter SHALL all read 0 in the following cycle.
REQ-029 rst SHALL override start and abort.
REQ-030 Reset mid-sweep SHALL discard the sweep with no done pulse.

Structure
REQ-031 Package sweep4_pkg SHALL hold the state enum, NUM_VEC=16 and RESP_W=32.
REQ-032 The hold counter SHALL be one sub-module, sweep4_hold_cnt (inputs clear and enable; output last flag).

Verification
REQ-033 Downstream model f=a&b, g=c|d, HOLD_CYCLES=20, start pulsed at cycle T -> busy is high for cycles T+1..T+320, done pulses at T+321, and resp=32'hFE545454.
REQ-034 With HOLD_CYCLES=20, monitor a..d -> they step 0000..1111, each value held exactly 20 cycles, a is MSB.
REQ-035 Abort at cycle T+45 -> IDLE at T+46, no done pulse, and resp[3:0] holds the captures for vectors 0 and 1 with higher bits 0.
REQ-036 rst asserted at T+100 mid-sweep -> all outputs are 0 the next cycle; a subsequent start runs a full sweep correctly.
REQ-037 start re-pulsed during DRIVE and in the DONE cycle, plus start and abort together in IDLE -> the re-pulses are ignored, and the simultaneous pulse starts a sweep.
REQ-038 HOLD_CYCLES=1 -> the sweep takes 16 cycles, done pulses at T+17, and resp is correct.
